// File: rtl/if_stage.sv
// Instruction fetch stage: credit-limited fetch requests, in-order response
// tagging, a 2-entry instruction queue and the decode-facing pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        arst_n,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]  pc_q;
  logic [1:0]   outstanding_q;
  logic [1:0]   drop_count_q;

  logic [31:0]  tag_mem_q [2];
  logic         tag_wr_q;
  logic         tag_rd_q;

  fetch_entry_t iq_mem_q [2];
  logic         iq_wr_q;
  logic         iq_rd_q;
  logic [1:0]   iq_count_q;

  logic         accept;
  logic         rsp_keep;
  logic         iq_empty;
  logic         load;
  logic         iq_push;
  logic         iq_pop;
  fetch_entry_t rsp_entry;
  fetch_entry_t head_entry;
  logic         unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  assign iq_empty = (iq_count_q == 2'd0);

  // Credits cover both queued and in-flight words (stale ones included), so the
  // queue can never be asked to hold more than two entries.
  // NOTE: the reset term keeps the request low while arst_n is asserted; the
  // credit expression alone would already read "free" out of reset.
  assign imem_req_valid_o = arst_n && !redirect_i &&
                            (({1'b0, iq_count_q} + {1'b0, outstanding_q}) < 3'd2);
  assign imem_req_addr_o  = pc_q;
  assign accept           = imem_req_valid_o && imem_req_ready_i;

  // A response seen during a redirect, or while stale words are pending, is discarded.
  assign rsp_keep  = imem_rsp_valid_i && (drop_count_q == 2'd0) && !redirect_i;
  assign rsp_entry = '{inst: imem_rsp_data_i, pc: tag_mem_q[tag_rd_q]};

  // An empty queue forwards the arriving response straight into decode.
  assign head_entry = iq_empty ? rsp_entry : iq_mem_q[iq_rd_q];
  assign load       = !flush_i && !redirect_i && !stall_i && (!iq_empty || rsp_keep);
  assign iq_pop     = load && !iq_empty;
  assign iq_push    = rsp_keep && !(load && iq_empty);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc_q          <= {RESET_PC[31:2], 2'b00};
      outstanding_q <= 2'd0;
      drop_count_q  <= 2'd0;
      tag_wr_q      <= 1'b0;
      tag_rd_q      <= 1'b0;
    end else begin
      if (redirect_i) begin
        pc_q <= {redirect_pc_i[31:2], 2'b00};
      end else if (accept) begin
        pc_q <= pc_q + 32'd4;
      end

      outstanding_q <= outstanding_q + {1'b0, accept} - {1'b0, imem_rsp_valid_i};

      // Every word still in flight after a redirect is stale, including those
      // already marked by an earlier redirect.
      if (redirect_i) begin
        drop_count_q <= outstanding_q - {1'b0, imem_rsp_valid_i};
      end else if (imem_rsp_valid_i && (drop_count_q != 2'd0)) begin
        drop_count_q <= drop_count_q - 2'd1;
      end

      if (accept) begin
        tag_wr_q <= ~tag_wr_q;
      end
      if (imem_rsp_valid_i) begin
        tag_rd_q <= ~tag_rd_q;
      end
    end
  end

  // NOTE: storage arrays carry no reset; the pointers and counts that qualify
  // them do, so the contents are never observed before being written.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem_q[tag_wr_q] <= pc_q;
    end
    if (iq_push) begin
      iq_mem_q[iq_wr_q] <= rsp_entry;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      iq_wr_q    <= 1'b0;
      iq_rd_q    <= 1'b0;
      iq_count_q <= 2'd0;
    end else if (redirect_i) begin
      iq_wr_q    <= 1'b0;
      iq_rd_q    <= 1'b0;
      iq_count_q <= 2'd0;
    end else begin
      if (iq_push) begin
        iq_wr_q <= ~iq_wr_q;
      end
      if (iq_pop) begin
        iq_rd_q <= ~iq_rd_q;
      end
      iq_count_q <= iq_count_q + {1'b0, iq_push} - {1'b0, iq_pop};
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      id_valid_o <= 1'b0;
      id_inst_o  <= NOP_INST;
      id_pc_o    <= 32'd0;
      id_pc4_o   <= 32'd0;
    end else if (flush_i || redirect_i) begin
      id_valid_o <= 1'b0;
      id_inst_o  <= NOP_INST;
      id_pc_o    <= 32'd0;
      id_pc4_o   <= 32'd0;
    end else if (!stall_i) begin
      if (load) begin
        id_valid_o <= 1'b1;
        id_inst_o  <= head_entry.inst;
        id_pc_o    <= head_entry.pc;
        id_pc4_o   <= head_entry.pc + 32'd4;
      end else begin
        id_valid_o <= 1'b0;
        id_inst_o  <= NOP_INST;
        id_pc_o    <= 32'd0;
        id_pc4_o   <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: in-order memory model plus a scoreboard of
// fetched addresses that must reach decode in order, exactly once.
module tb_if_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc4_o;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .id_valid_o       (id_valid_o),
    .id_inst_o        (id_inst_o),
    .id_pc_o          (id_pc_o),
    .id_pc4_o         (id_pc4_o)
  );

  typedef struct packed {
    logic        v;
    logic        chk_pc;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } dec_t;

  logic [31:0] sb [$];
  logic [31:0] mem_q [$];
  logic [31:0] exp_fetch;
  logic        mem_hold;
  logic        prev_stall;
  logic        prev_bubble;
  dec_t        last_exp;

  logic        obs_valid;
  logic        obs_req_valid;
  logic [31:0] obs_inst;
  logic [31:0] obs_pc;
  logic [31:0] obs_pc4;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check decode and request at the falling edge, then
  // present the memory response for the next cycle just after the rising edge.
  task automatic step();
    dec_t        e;
    logic [31:0] f;
    @(negedge clk);
    obs_valid     = id_valid_o;
    obs_inst      = id_inst_o;
    obs_pc        = id_pc_o;
    obs_pc4       = id_pc4_o;
    obs_req_valid = imem_req_valid_o;

    if (prev_bubble) begin
      e = '{v: 1'b0, chk_pc: 1'b1, inst: NOP, pc: 32'd0, pc4: 32'd0};
    end else if (prev_stall) begin
      e = last_exp;
    end else if (id_valid_o) begin
      if (sb.size() == 0) begin
        check("sb_underrun", 32'(sb.size()), 32'd1);
        f = '1;
      end else begin
        f = sb.pop_front();
      end
      e = '{v: 1'b1, chk_pc: 1'b1, inst: f ^ MASK, pc: f, pc4: f + 32'd4};
    end else begin
      e = '{v: 1'b0, chk_pc: 1'b0, inst: NOP, pc: 32'd0, pc4: 32'd0};
    end
    check("id_valid", {31'b0, id_valid_o}, {31'b0, e.v});
    check("id_inst", id_inst_o, e.inst);
    if (e.chk_pc) begin
      check("id_pc", id_pc_o, e.pc);
      check("id_pc4", id_pc4_o, e.pc4);
    end
    last_exp = e;

    if (redirect_i) begin
      check("req_valid_in_redirect", {31'b0, imem_req_valid_o}, 32'd0);
      sb.delete();
      exp_fetch = {redirect_pc_i[31:2], 2'b00};
    end else if (imem_req_valid_o) begin
      check("req_addr", imem_req_addr_o, exp_fetch);
      if (imem_req_ready_i) begin
        sb.push_back(exp_fetch);
        mem_q.push_back(imem_req_addr_o);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    prev_stall  = stall_i;
    prev_bubble = flush_i | redirect_i;

    @(posedge clk);
    #1;
    if (!mem_hold && mem_q.size() != 0) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_q.pop_front() ^ MASK;
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = 32'd0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {31'b0, imem_req_valid_o}, 32'd0);
    check({tag, "_id_valid"}, {31'b0, id_valid_o}, 32'd0);
    check({tag, "_id_inst"}, id_inst_o, NOP);
    check({tag, "_id_pc"}, id_pc_o, 32'd0);
    check({tag, "_id_pc4"}, id_pc4_o, 32'd0);
  endtask

  // Run until the first valid decode entry and check it against a target PC.
  task automatic expect_first_pc(input string tag, input logic [31:0] target);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!found && obs_valid) begin
        found = 1'b1;
        check({tag, "_pc"}, obs_pc, target);
        check({tag, "_pc4"}, obs_pc4, target + 32'd4);
      end
    end
    check({tag, "_seen"}, {31'b0, found}, 32'd1);
  endtask

  initial begin
    logic found;
    arst_n           = 1'b0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'd0;
    stall_i          = 1'b0;
    flush_i          = 1'b0;
    redirect_i       = 1'b0;
    redirect_pc_i    = 32'd0;
    mem_hold         = 1'b0;
    exp_fetch        = 32'd0;
    prev_stall       = 1'b0;
    prev_bubble      = 1'b1;
    last_exp         = '0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    arst_n = 1'b1;

    // Zero-wait streaming: accept in cycle 0, decode valid from cycle 2.
    step();
    check("first_req_valid", {31'b0, obs_req_valid}, 32'd1);
    step();
    step();
    check("latency_valid", {31'b0, obs_valid}, 32'd1);
    check("latency_pc", obs_pc, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stream_valid", {31'b0, obs_valid}, 32'd1);
    end

    // Stall long enough to fill the queue; requests must stop.
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 1) check("stall_req_valid", {31'b0, obs_req_valid}, 32'd0);
    end
    stall_i = 1'b0;
    repeat (4) step();

    // Single-cycle flush bubbles decode without losing the queued stream.
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    step();
    check("flush_valid", {31'b0, obs_valid}, 32'd0);
    check("flush_inst", obs_inst, NOP);
    repeat (3) step();

    // Two words outstanding; the first stale word arrives in the redirect cycle.
    mem_hold = 1'b1;
    repeat (3) step();
    mem_hold = 1'b0;
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    step();
    redirect_i = 1'b0;
    expect_first_pc("redirect", 32'h0000_0100);

    // Back-to-back redirects: only the last target may reach decode.
    mem_hold = 1'b1;
    repeat (3) step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0203;
    step();
    redirect_pc_i = 32'h0000_1002;
    mem_hold      = 1'b0;
    step();
    redirect_i = 1'b0;
    expect_first_pc("redirect2", 32'h0000_1000);

    // Address wrap at the top of the address space.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    step();
    redirect_i = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_valid && obs_pc == 32'hFFFF_FFFC) begin
        found = 1'b1;
        check("wrap_pc4", obs_pc4, 32'd0);
      end
    end
    check("wrap_seen", {31'b0, found}, 32'd1);

    // Memory not ready: request held, decode drains to bubbles.
    imem_req_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("notready_req_valid", {31'b0, obs_req_valid}, 32'd1);
      if (i >= 2) begin
        check("notready_bubble_valid", {31'b0, obs_valid}, 32'd0);
        check("notready_bubble_inst", obs_inst, NOP);
      end
    end
    imem_req_ready_i = 1'b1;
    repeat (5) step();

    // Asynchronous reset in the middle of streaming.
    #2 arst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    mem_q.delete();
    sb.delete();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'd0;
    exp_fetch        = 32'd0;
    prev_bubble      = 1'b1;
    prev_stall       = 1'b0;
    @(posedge clk);
    #1 arst_n = 1'b1;
    expect_first_pc("after_reset", 32'd0);

    // Drain: every accepted fetch must have reached decode.
    imem_req_ready_i = 1'b0;
    repeat (6) step();
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the bubble instruction (addi x0,x0,0) presented to decode.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 arst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req_valid_o  output  1  fetch request valid.
REQ-006 imem_req_ready_i  input  1  instruction memory accepts the request.
REQ-007 imem_req_addr_o  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid_i  input  1  response valid; responses return in request order, no backpressure.
REQ-009 imem_rsp_data_i  input  32  fetched instruction word.
REQ-010 stall_i  input  1  hazard-unit stall: hold the decode-facing register.
REQ-011 flush_i  input  1  hazard-unit flush: bubble the decode-facing register.
REQ-012 redirect_i  input  1  taken branch/jump resolved downstream.
REQ-013 redirect_pc_i  input  32  redirect target.
REQ-014 id_valid_o  output  1  decode-facing entry holds a real instruction.
REQ-015 id_inst_o / id_pc_o / id_pc4_o  output  32 each  instruction, its address, address+4 (decode input record).

Function
REQ-016 PC register SHALL drive imem_req_addr_o; bits [1:0] always 0 (redirect_pc_i[1:0] ignored).
REQ-017 imem_req_valid_o SHALL be 1 iff (queue_count + outstanding) < 2 and redirect_i = 0.
REQ-018 On accept (valid & ready): PC += 4 mod 2^32 (0xFFFF_FFFC wraps to 0), outstanding += 1, request address pushed into a 2-entry in-order tag FIFO.
REQ-019 While valid and not ready, address SHALL stay stable unless redirect_i.
REQ-020 Response with drop_count = 0: pushed into a 2-entry instruction queue as {data, tag-FIFO head}; tag popped; outstanding -= 1.
REQ-021 Response with drop_count > 0: discarded; drop_count -= 1; outstanding -= 1; tag popped.
REQ-022 Response and accept in the same cycle: outstanding unchanged.
REQ-023 Decode register update, priority order: flush_i or redirect_i -> NOP_INST, valid 0, pc/pc4 0; else stall_i -> hold all id_* and do not pop queue; else queue non-empty -> load head, valid 1, pop; else -> NOP_INST, valid 0.
REQ-024 id_pc4_o SHALL equal id_pc_o + 4 mod 2^32 whenever id_valid_o = 1.
REQ-025 redirect_i: PC <= redirect_pc_i; instruction queue cleared; drop_count <= outstanding minus any response arriving that cycle; tag FIFO entries kept for dropped responses; no request issued that cycle; request to target asserted next cycle.
REQ-026 Response arriving in the redirect cycle SHALL be discarded.
REQ-027 Back-to-back redirects: latest target wins; drop_count accumulates so that every stale response is discarded.
REQ-028 Queue SHALL never overflow (credit rule REQ-017); push and pop in the same cycle on a full queue SHALL be legal.
REQ-029 Fetch-to-decode latency with zero-wait memory: request accepted cycle N, response N+1, id_valid_o = 1 from N+2.

Reset
REQ-030 During reset: PC = RESET_PC, queues empty, outstanding = drop_count = 0, imem_req_valid_o = 0, id_valid_o = 0, id_inst_o = NOP_INST, id_pc_o = id_pc4_o = 0.
REQ-031 First request SHALL be issued the first cycle after arst_n deasserts; reset mid-transfer SHALL discard all in-flight state, and late responses after reset SHALL be ignored by the bench contract (memory also reset).

Verification
REQ-032 Reset release, ready = 1, 1-cycle memory returning addr^0xA5A5_0000 -> id_pc_o = 0,4,8,... consecutively from cycle 3, id_valid_o = 1 continuously.
REQ-033 stall_i held 3 cycles with queue full -> id_* frozen, imem_req_valid_o = 0, no instruction lost or duplicated after release.
REQ-034 redirect_i to 0x0000_0100 with 2 outstanding -> both responses dropped, next id_pc_o valid = 0x100, id_pc4_o = 0x104.
REQ-035 flush_i for 1 cycle -> id_inst_o = 0x0000_0013, id_valid_o = 0 that cycle; stream resumes with next queued PC.
REQ-036 PC at 0xFFFF_FFFC -> following fetch address 0x0000_0000, id_pc4_o = 0x0000_0000.
REQ-037 imem_req_ready_i = 0 for 5 cycles then 1 -> address stable throughout, id_valid_o = 0 bubbles, no duplicate PCs.
